// File: rtl/gf_pkg.sv
// gf_pkg: GF(2^8) field parameters (x^8+x^4+x^3+x^2+1) and arithmetic helpers
// shared by the Reed-Solomon decoder stages, plus the Forney FSM state type.
package gf_pkg;

  localparam int SYMB_WIDTH = 8;
  localparam int T_LEN      = 8;
  localparam int SYMB_NUM   = (1 << SYMB_WIDTH) - 1;
  localparam int CNT_W      = $clog2(T_LEN);
  localparam int NUM_W      = $clog2(T_LEN + 1);

  typedef logic [SYMB_WIDTH-1:0] symb_t;

  // Low bits of the field polynomial; the x^8 term is implied by the shift.
  localparam symb_t GF_POLY = 8'h1D;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_e;

  function automatic symb_t gf_mult(input symb_t a, input symb_t b);
    symb_t acc;
    symb_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[SYMB_WIDTH-1] ? ((sh << 1) ^ GF_POLY) : (sh << 1);
    end
    return acc;
  endfunction

  function automatic symb_t gf_pow(input symb_t base, input symb_t e);
    symb_t r;
    symb_t b;
    r = symb_t'(1);
    b = base;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (e[i]) r = gf_mult(r, b);
      b = gf_mult(b, b);
    end
    return r;
  endfunction

  function automatic symb_t alpha_to_symb(input symb_t e);
    return gf_pow(symb_t'(2), e);
  endfunction

  // a^(2^m-2) is the multiplicative inverse; zero maps to zero.
  function automatic symb_t gf_inv(input symb_t a);
    return gf_pow(a, symb_t'(SYMB_NUM - 1));
  endfunction

endpackage

// File: rtl/rs_poly_eval.sv
// rs_poly_eval: combinational Horner evaluation of a GF(2^m) polynomial of
// degree DEGREE at one point; coefficient index equals power of x.
module rs_poly_eval
  import gf_pkg::*;
#(
  parameter int DEGREE = T_LEN - 1
) (
  input  logic [DEGREE:0][SYMB_WIDTH-1:0] coeff_i,
  input  logic [SYMB_WIDTH-1:0]           x_i,
  output logic [SYMB_WIDTH-1:0]           y_o
);

  always_comb begin
    y_o = coeff_i[DEGREE];
    for (int k = DEGREE - 1; k >= 0; k--) begin
      y_o = gf_mult(y_o, x_i) ^ coeff_i[k];
    end
  end

endmodule

// File: rtl/rs_forney.sv
// rs_forney: Forney error-magnitude stage, one error slot per cycle.
// Define RS_FORNEY_PIPE_EN to register the evaluator outputs ahead of the division.
module rs_forney
  import gf_pkg::*;
#(
  parameter int FCR = 0
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [T_LEN:0][SYMB_WIDTH-1:0]      error_locator,
  input  logic [T_LEN-1:0][SYMB_WIDTH-1:0]    error_evaluator,
  input  logic [T_LEN-1:0][SYMB_WIDTH-1:0]    error_positions,
  input  logic                                error_positions_vld,
  input  logic                                rs_chien_err,
  output logic [T_LEN-1:0][SYMB_WIDTH-1:0]    error_values,
  output logic [T_LEN-1:0][SYMB_WIDTH-1:0]    error_positions_o,
  output logic                                error_values_vld,
  output logic                                rs_forney_err,
  output logic                                busy,
  output fsm_state_e                          dbg_state_o
);

  // Handshake: error_positions_vld is a one-cycle pulse with no back-pressure; it
  // always captures (restarting any job), and error_values_vld pulses once per
  // completed job with results held until the next capture.

  // X^(1-FCR) reduced to a non-negative exponent of X.
  localparam int X_EXP = (((1 - FCR) % SYMB_NUM) + SYMB_NUM) % SYMB_NUM;

  fsm_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    vld_q, vld_d;

  logic [T_LEN-1:0][SYMB_WIDTH-1:0] dlam_q, dlam_in;
  logic [T_LEN-1:0][SYMB_WIDTH-1:0] omega_q;
  logic [T_LEN-1:0][SYMB_WIDTH-1:0] pos_q;
  logic [T_LEN-1:0][SYMB_WIDTH-1:0] values_q;
  logic                    chien_q;
  logic [NUM_W-1:0]        err_num_q, err_num_in;
  logic                    err_acc_q;
  logic                    forney_err_q;

  symb_t                   p_val, inv_exp, xinv, scale, omega_y, lam_y;
  logic                    slot_active;

  logic                    wb_valid;
  logic [CNT_W-1:0]        wb_slot;
  logic                    wb_active;
  symb_t                   wb_omega, wb_lam, wb_scale, wb_value;

  always_comb begin
    err_num_in = '0;
    for (int k = 0; k <= T_LEN; k++) begin
      if (error_locator[k] != '0) err_num_in = NUM_W'(k);
    end
  end

  // Formal derivative in characteristic 2: only odd-power terms survive.
  always_comb begin
    dlam_in = '0;
    for (int k = 0; k < T_LEN; k += 2) begin
      dlam_in[k] = error_locator[k+1];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    if (error_positions_vld) begin
      state_d = ST_EVAL;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_EVAL: begin
          if (cnt_q == CNT_W'(T_LEN - 1)) begin
            cnt_d = '0;
`ifdef RS_FORNEY_PIPE_EN
            state_d = ST_DRAIN;
`else
            state_d = ST_DONE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DRAIN: state_d = ST_DONE;
        ST_DONE: begin
          state_d = ST_IDLE;
          vld_d   = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign p_val       = pos_q[cnt_q];
  assign inv_exp     = (p_val == '0) ? '0 : (symb_t'(SYMB_NUM) - p_val);
  assign xinv        = alpha_to_symb(inv_exp);
  assign scale       = gf_pow(alpha_to_symb(p_val), symb_t'(X_EXP));
  assign slot_active = (NUM_W'(cnt_q) < err_num_q) && !chien_q;

  rs_poly_eval #(.DEGREE(T_LEN - 1)) u_omega_eval (
    .coeff_i (omega_q),
    .x_i     (xinv),
    .y_o     (omega_y)
  );

  rs_poly_eval #(.DEGREE(T_LEN - 1)) u_dlam_eval (
    .coeff_i (dlam_q),
    .x_i     (xinv),
    .y_o     (lam_y)
  );

`ifdef RS_FORNEY_PIPE_EN
  logic             pipe_vld_q;
  logic [CNT_W-1:0] pipe_slot_q;
  logic             pipe_active_q;
  symb_t            pipe_omega_q, pipe_lam_q, pipe_scale_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) pipe_vld_q <= 1'b0;
    else          pipe_vld_q <= (state_q == ST_EVAL) && !error_positions_vld;
  end

  always_ff @(posedge aclk) begin
    pipe_slot_q   <= cnt_q;
    pipe_active_q <= slot_active;
    pipe_omega_q  <= omega_y;
    pipe_lam_q    <= lam_y;
    pipe_scale_q  <= scale;
  end

  assign wb_valid  = pipe_vld_q;
  assign wb_slot   = pipe_slot_q;
  assign wb_active = pipe_active_q;
  assign wb_omega  = pipe_omega_q;
  assign wb_lam    = pipe_lam_q;
  assign wb_scale  = pipe_scale_q;
`else
  assign wb_valid  = (state_q == ST_EVAL);
  assign wb_slot   = cnt_q;
  assign wb_active = slot_active;
  assign wb_omega  = omega_y;
  assign wb_lam    = lam_y;
  assign wb_scale  = scale;
`endif

  assign wb_value = gf_mult(gf_mult(wb_scale, wb_omega), gf_inv(wb_lam));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dlam_q       <= '0;
      omega_q      <= '0;
      pos_q        <= '0;
      chien_q      <= 1'b0;
      err_num_q    <= '0;
      values_q     <= '0;
      err_acc_q    <= 1'b0;
      forney_err_q <= 1'b0;
    end else if (error_positions_vld) begin
      dlam_q    <= dlam_in;
      omega_q   <= error_evaluator;
      pos_q     <= error_positions;
      chien_q   <= rs_chien_err;
      err_num_q <= err_num_in;
      values_q  <= '0;
      err_acc_q <= 1'b0;
    end else begin
      if (wb_valid) begin
        values_q[wb_slot] <= wb_active ? wb_value : '0;
        if (wb_active && (wb_lam == '0)) err_acc_q <= 1'b1;
      end
      if (state_q == ST_DONE) forney_err_q <= err_acc_q | chien_q;
    end
  end

  assign error_values      = values_q;
  assign error_positions_o = pos_q;
  assign error_values_vld  = vld_q;
  assign rs_forney_err     = forney_err_q;
  assign busy              = (state_q != ST_IDLE);
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_rs_forney.sv
// tb_rs_forney: directed checks of the Forney stage; stimulus polynomials come
// from an encoder-side error model, expected magnitudes are the injected ones.
module tb_rs_forney;
  import gf_pkg::*;

`ifdef RS_FORNEY_PIPE_EN
  localparam int LAT = T_LEN + 3;
`else
  localparam int LAT = T_LEN + 2;
`endif

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [T_LEN:0][SYMB_WIDTH-1:0]   lam_v;
  logic [T_LEN-1:0][SYMB_WIDTH-1:0] omg_v, pos_v, exp_vals, values_o, pos_o;
  logic vld_i, chien_i, vld_o, err_o, busy_o;
  logic [1:0] state_o;

  int n_checks, n_errors;
  int gexp[0:509];
  int glog[0:255];
  int job_pos[T_LEN];
  int job_mag[T_LEN];

  rs_forney #(.FCR(0)) dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .error_locator       (lam_v),
    .error_evaluator     (omg_v),
    .error_positions     (pos_v),
    .error_positions_vld (vld_i),
    .rs_chien_err        (chien_i),
    .error_values        (values_o),
    .error_positions_o   (pos_o),
    .error_values_vld    (vld_o),
    .rs_forney_err       (err_o),
    .busy                (busy_o),
    .dbg_state_o         (state_o)
  );

  // Clock / watchdog
  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic gf_init();
    int v;
    v = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = v;
      glog[v] = i;
      v = v << 1;
      if ((v & 256) != 0) v = v ^ 'h11D;
    end
    for (int i = 255; i < 510; i++) gexp[i] = gexp[i-255];
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[glog[a] + glog[b]];
  endfunction

  // Lambda = prod(1 + X_k x), S_j = sum Y_k X_k^j, Omega = S*Lambda mod x^(2t).
  task automatic build_job(input int n);
    int lam[T_LEN+1];
    int syn[2*T_LEN];
    int x, acc;
    for (int j = 0; j <= T_LEN; j++) lam[j] = 0;
    lam[0] = 1;
    for (int k = 0; k < n; k++) begin
      x = gexp[job_pos[k]];
      for (int j = T_LEN; j >= 1; j--) lam[j] = lam[j] ^ gmul(x, lam[j-1]);
    end
    for (int j = 0; j < 2*T_LEN; j++) begin
      acc = 0;
      for (int k = 0; k < n; k++) acc = acc ^ gmul(job_mag[k], gexp[(job_pos[k] * j) % 255]);
      syn[j] = acc;
    end
    for (int i = 0; i <= T_LEN; i++) lam_v[i] = SYMB_WIDTH'(lam[i]);
    for (int i = 0; i < T_LEN; i++) begin
      acc = 0;
      for (int j = 0; j <= i; j++) acc = acc ^ gmul(syn[j], lam[i-j]);
      omg_v[i]    = SYMB_WIDTH'(acc);
      pos_v[i]    = (i < n) ? SYMB_WIDTH'(job_pos[i]) : '0;
      exp_vals[i] = (i < n) ? SYMB_WIDTH'(job_mag[i]) : '0;
    end
  endtask

  task automatic load_single_p5();
    lam_v = '0; lam_v[0] = 8'h01; lam_v[1] = 8'h20;
    omg_v = '0; omg_v[0] = 8'h3A;
    pos_v = '0; pos_v[0] = 8'd5;
    exp_vals = '0; exp_vals[0] = 8'h3A;
  endtask

  // Pulse is raised in cycle 0; returns at the falling edge of cycle 1.
  task automatic send_job(input logic chien);
    @(negedge aclk);
    chien_i = chien;
    vld_i   = 1'b1;
    @(negedge aclk);
    vld_i   = 1'b0;
    chien_i = 1'b0;
  endtask

  task automatic wait_vld(input string tag);
    int cyc;
    bit seen;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (vld_o) seen = 1'b1;
      else begin
        @(negedge aclk);
        cyc++;
      end
    end
    check_eq({tag, "_lat"}, 64'(seen ? cyc : 0), 64'(LAT));
  endtask

  task automatic run_check(input string tag, input logic exp_err);
    wait_vld(tag);
    check_eq({tag, "_vals"}, values_o, exp_vals);
    check_eq({tag, "_err"}, 64'(err_o), 64'(exp_err));
    check_eq({tag, "_pos"}, pos_o, pos_v);
    @(negedge aclk);
    check_eq({tag, "_pulse"}, 64'(vld_o), 64'(0));
  endtask

  initial begin
    int cnt;
    n_checks = 0;
    n_errors = 0;
    vld_i = 1'b0;
    chien_i = 1'b0;
    lam_v = '0;
    omg_v = '0;
    pos_v = '0;
    exp_vals = '0;
    gf_init();

    repeat (3) @(negedge aclk);
    check_eq("rst_vals", values_o, 64'(0));
    check_eq("rst_pos", pos_o, 64'(0));
    check_eq("rst_vld", 64'(vld_o), 64'(0));
    check_eq("rst_err", 64'(err_o), 64'(0));
    check_eq("rst_busy", 64'(busy_o), 64'(0));
    check_eq("rst_state", 64'(state_o), 64'(0));
    aresetn = 1'b1;
    @(negedge aclk);

    load_single_p5();
    send_job(1'b0);
    check_eq("single_busy", 64'(busy_o), 64'(1));
    run_check("single", 1'b0);
    check_eq("single_idle", 64'(busy_o), 64'(0));
    repeat (3) @(negedge aclk);
    check_eq("single_hold", values_o, exp_vals);

    job_pos = '{0, 1, 2, 3, 100, 200, 253, 254};
    job_mag = '{1, 2, 3, 4, 5, 6, 7, 8};
    build_job(8);
    send_job(1'b0);
    run_check("eight", 1'b0);

    job_pos[0] = 5; job_mag[0] = 'h3A;
    build_job(1);
    exp_vals = '0;
    send_job(1'b1);
    run_check("chien", 1'b1);

    lam_v = '0; lam_v[0] = 8'h01;
    omg_v = '0; omg_v[0] = 8'h55;
    for (int i = 0; i < T_LEN; i++) pos_v[i] = 8'd9;
    exp_vals = '0;
    send_job(1'b0);
    run_check("nerr0", 1'b0);

    lam_v = '0; lam_v[0] = 8'h01; lam_v[2] = 8'h01;
    omg_v = '0; omg_v[0] = 8'h11;
    pos_v = '0; pos_v[0] = 8'd3; pos_v[1] = 8'd7;
    send_job(1'b0);
    wait_vld("deriv0");
    check_eq("deriv0_err", 64'(err_o), 64'(1));
    @(negedge aclk);

    job_pos = '{0, 1, 2, 3, 100, 200, 253, 254};
    job_mag = '{1, 2, 3, 4, 5, 6, 7, 8};
    build_job(8);
    send_job(1'b0);
    repeat (2) @(negedge aclk);
    job_pos[0] = 77; job_mag[0] = 'hC4;
    build_job(1);
    send_job(1'b0);
    run_check("restart", 1'b0);

    job_pos = '{0, 1, 2, 3, 100, 200, 253, 254};
    job_mag = '{1, 2, 3, 4, 5, 6, 7, 8};
    build_job(8);
    send_job(1'b0);
    repeat (4) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check_eq("midrst_vals", values_o, 64'(0));
    check_eq("midrst_pos", pos_o, 64'(0));
    check_eq("midrst_busy", 64'(busy_o), 64'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(negedge aclk);
      if (vld_o) cnt++;
    end
    check_eq("midrst_novld", 64'(cnt), 64'(0));

    load_single_p5();
    send_job(1'b0);
    run_check("after_rst", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
